// File: rtl/bus_initiator_if.sv
// Host command/response and bus control signals of the bus initiator.
// The tri-state data bus is kept as a plain inout on the initiator.
interface bus_initiator_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_rw;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       ce;
    logic       rw;
    logic [1:0] address;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rw, rsp_rdata, busy, ce, rw, address
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rw, rsp_rdata, busy, ce, rw, address
    );
endinterface

// File: rtl/bus_initiator.sv
// Single-command bus initiator: turns host commands into timed ce/rw/address
// cycles on a shared tri-state register-file bus.
//
// state  | meaning
// IDLE   | bus parked, data released, ready for a command
// ACCESS | ce high for ACCESS_CYCLES, write data driven for writes
// TURN   | post-read idle cycles so the responder releases the bus
module bus_initiator #(
    parameter int unsigned ACCESS_CYCLES = 1,
    parameter int unsigned TURN_CYCLES   = 1
) (
    input  logic            clock,
    input  logic            reset,
    bus_initiator_if.master bif,
    inout  wire  [7:0]      data
);

    typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

    localparam logic [3:0] ACC_LOAD  = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       lat_rw_q;
    logic [1:0] lat_addr_q;
    logic [7:0] lat_wdata_q;
    logic       ce_q, ce_d;
    logic       bus_rw_q, bus_rw_d;
    logic [1:0] bus_addr_q, bus_addr_d;
    logic       drive_q;
    logic       next_rw;
    logic [1:0] next_addr;
    logic       rsp_valid_q, rsp_rw_q;
    logic [7:0] rsp_rdata_q;
    logic       cmd_ready;
    logic       accept;
    logic       last_access;

    // Ready depends only on registered state; held low while reset is asserted.
    assign cmd_ready   = (state_q == IDLE) && !reset;
    assign accept      = bif.cmd_valid && cmd_ready;
    assign last_access = (state_q == ACCESS) && (cnt_q == 4'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        next_rw   = accept ? bif.cmd_rw   : lat_rw_q;
        next_addr = accept ? bif.cmd_addr : lat_addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ACCESS;
                    cnt_d   = ACC_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (lat_rw_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = TURN;
                        cnt_d   = TURN_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        // Bus controls are computed from the next state so they can be registered.
        ce_d       = (state_d == ACCESS);
        bus_rw_d   = ce_d && next_rw;
        bus_addr_d = ce_d ? next_addr : 2'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lat_rw_q    <= 1'b0;
            lat_addr_q  <= 2'd0;
            lat_wdata_q <= 8'h00;
            ce_q        <= 1'b0;
            bus_rw_q    <= 1'b0;
            bus_addr_q  <= 2'd0;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rw_q    <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ce_q       <= ce_d;
            bus_rw_q   <= bus_rw_d;
            bus_addr_q <= bus_addr_d;
            drive_q    <= bus_rw_d;
            if (accept) begin
                lat_rw_q    <= bif.cmd_rw;
                lat_addr_q  <= bif.cmd_addr;
                lat_wdata_q <= bif.cmd_wdata;
            end
            rsp_valid_q <= last_access;
            if (last_access) begin
                rsp_rw_q <= lat_rw_q;
                if (!lat_rw_q) begin
                    rsp_rdata_q <= data;
                end
            end
        end
    end

    assign data = drive_q ? lat_wdata_q : 8'hzz;

    assign bif.cmd_ready = cmd_ready;
    assign bif.busy      = (state_q != IDLE);
    assign bif.ce        = ce_q;
    assign bif.rw        = bus_rw_q;
    assign bif.address   = bus_addr_q;
    assign bif.rsp_valid = rsp_valid_q;
    assign bif.rsp_rw    = rsp_rw_q;
    assign bif.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: default-timing instance against a
// falling-edge register-file responder, plus a slow-timing instance.
module tb_bus_initiator;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_initiator_if bif0 ();
    bus_initiator_if bif1 ();
    wire [7:0] data0;
    wire [7:0] data1;

    bus_initiator dut0 (.clock(clk), .reset(reset), .bif(bif0), .data(data0));
    bus_initiator #(.ACCESS_CYCLES(3), .TURN_CYCLES(2)) dut1 (.clock(clk), .reset(reset), .bif(bif1), .data(data1));

    int n_cmp = 0;
    int n_bad = 0;
    int viol  = 0;

    // Responder 0: register file, captures writes and starts/stops driving on falling edges.
    logic [7:0] regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic       r0_drive = 1'b0;
    logic [7:0] r0_val   = 8'h00;
    always @(negedge clk) begin
        if (bif0.ce && bif0.rw) regs[bif0.address] <= data0;
        r0_drive <= bif0.ce && !bif0.rw;
        r0_val   <= regs[bif0.address];
    end
    assign data0 = r0_drive ? r0_val : 8'hzz;

    // Responder 1: always returns 8'h3C on reads.
    logic r1_drive = 1'b0;
    always @(negedge clk) r1_drive <= bif1.ce && !bif1.rw;
    assign data1 = r1_drive ? 8'h3C : 8'hzz;

    function automatic logic released(input logic [7:0] v);
        return (v === 8'hzz) || (v === 8'h00);
    endfunction

    // Bus ownership monitor for instance 0.
    always begin
        @(posedge clk);
        #2;
        if (r0_drive && data0 !== r0_val) viol++;
        if (bif0.ce && !bif0.rw && !r0_drive && !released(data0)) viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic rw, input logic [1:0] addr, input logic [7:0] wd, input logic v);
        bif0.cmd_rw    = rw;
        bif0.cmd_addr  = addr;
        bif0.cmd_wdata = wd;
        bif0.cmd_valid = v;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bif0.cmd_ready && n < 20) begin tick(); n++; end
        n_cmp++; if (bif0.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wait_ready: cmd_ready=%b after %0d cycles, want 1", bif0.cmd_ready, n); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_cmd(1'b0, 2'd0, 8'h00, 1'b0);
        bif1.cmd_valid = 1'b0; bif1.cmd_rw = 1'b0; bif1.cmd_addr = 2'd0; bif1.cmd_wdata = 8'h00;
        tick(); tick();
        n_cmp++; if (bif0.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", bif0.cmd_ready); end
        n_cmp++; if (bif0.ce !== 1'b0) begin n_bad++; $display("FAIL rst_ce: got %b want 0", bif0.ce); end
        n_cmp++; if (bif0.rw !== 1'b0) begin n_bad++; $display("FAIL rst_rw: got %b want 0", bif0.rw); end
        n_cmp++; if (bif0.address !== 2'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", bif0.address); end
        n_cmp++; if (bif0.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bif0.busy); end
        n_cmp++; if (bif0.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", bif0.rsp_valid); end
        n_cmp++; if (bif0.rsp_rw !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_rw: got %b want 0", bif0.rsp_rw); end
        n_cmp++; if (bif0.rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rdata: got %h want 00", bif0.rsp_rdata); end
        n_cmp++; if (!released(data0)) begin n_bad++; $display("FAIL rst_data: got %h want released", data0); end
        n_cmp++; if (bif1.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready1: got %b want 0", bif1.cmd_ready); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bif0.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready: got %b want 1", bif0.cmd_ready); end
        n_cmp++; if (bif1.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready1: got %b want 1", bif1.cmd_ready); end
        tick();
    endtask

    task automatic test_write_read();
        set_cmd(1'b1, 2'd2, 8'hA5, 1'b1);
        tick();
        bif0.cmd_valid = 1'b0;
        n_cmp++; if (bif0.ce !== 1'b1) begin n_bad++; $display("FAIL wr_ce: got %b want 1", bif0.ce); end
        n_cmp++; if (bif0.rw !== 1'b1) begin n_bad++; $display("FAIL wr_rw: got %b want 1", bif0.rw); end
        n_cmp++; if (bif0.address !== 2'd2) begin n_bad++; $display("FAIL wr_addr: got %0d want 2", bif0.address); end
        n_cmp++; if (data0 !== 8'hA5) begin n_bad++; $display("FAIL wr_data: got %h want a5", data0); end
        n_cmp++; if (bif0.cmd_ready !== 1'b0 || bif0.busy !== 1'b1) begin n_bad++; $display("FAIL wr_ready_busy: got %b/%b want 0/1", bif0.cmd_ready, bif0.busy); end
        tick();
        n_cmp++; if (bif0.rsp_valid !== 1'b1 || bif0.rsp_rw !== 1'b1) begin n_bad++; $display("FAIL wr_rsp: got valid %b rw %b want 1/1", bif0.rsp_valid, bif0.rsp_rw); end
        n_cmp++; if (bif0.cmd_ready !== 1'b1 || bif0.ce !== 1'b0) begin n_bad++; $display("FAIL wr_done: got ready %b ce %b want 1/0", bif0.cmd_ready, bif0.ce); end
        n_cmp++; if (!released(data0)) begin n_bad++; $display("FAIL wr_release: got %h want released", data0); end
        n_cmp++; if (bif0.rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL wr_rdata_hold: got %h want 00", bif0.rsp_rdata); end
        set_cmd(1'b0, 2'd2, 8'h00, 1'b1);
        tick();
        bif0.cmd_valid = 1'b0;
        n_cmp++; if (bif0.ce !== 1'b1 || bif0.rw !== 1'b0 || bif0.address !== 2'd2) begin n_bad++; $display("FAIL rd_bus: got ce %b rw %b addr %0d want 1/0/2", bif0.ce, bif0.rw, bif0.address); end
        n_cmp++; if (!released(data0)) begin n_bad++; $display("FAIL rd_nodrive: got %h want released", data0); end
        tick();
        n_cmp++; if (bif0.rsp_valid !== 1'b1 || bif0.rsp_rw !== 1'b0) begin n_bad++; $display("FAIL rd_rsp: got valid %b rw %b want 1/0", bif0.rsp_valid, bif0.rsp_rw); end
        n_cmp++; if (bif0.rsp_rdata !== 8'hA5) begin n_bad++; $display("FAIL rd_rdata: got %h want a5", bif0.rsp_rdata); end
        n_cmp++; if (bif0.cmd_ready !== 1'b0 || bif0.busy !== 1'b1 || bif0.ce !== 1'b0) begin n_bad++; $display("FAIL rd_turn: got ready %b busy %b ce %b want 0/1/0", bif0.cmd_ready, bif0.busy, bif0.ce); end
        tick();
        n_cmp++; if (bif0.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_pulse: got %b want 0", bif0.rsp_valid); end
        n_cmp++; if (bif0.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rd_ready_back: got %b want 1", bif0.cmd_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] wv [4];
        logic [7:0] rd [4];
        int acc [4];
        int k, nr, cyc;
        wv = '{8'h11, 8'h22, 8'h33, 8'h44};
        acc = '{0, 0, 0, 0};
        rd = '{8'h00, 8'h00, 8'h00, 8'h00};
        k = 0; cyc = 0;
        set_cmd(1'b1, 2'd0, wv[0], 1'b1);
        while (k < 4 && cyc < 40) begin
            if (bif0.cmd_ready) begin acc[k] = cyc; k++; end
            tick(); cyc++;
            if (k < 4) set_cmd(1'b1, 2'(k), wv[k], 1'b1);
            else bif0.cmd_valid = 1'b0;
        end
        n_cmp++; if (k != 4) begin n_bad++; $display("FAIL b2b_wr_count: got %0d want 4", k); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (acc[i] - acc[i-1] != 2) begin n_bad++; $display("FAIL b2b_wr_gap%0d: got %0d want 2", i, acc[i] - acc[i-1]); end
        end
        tick();
        k = 0; nr = 0; cyc = 0;
        set_cmd(1'b0, 2'd0, 8'h00, 1'b1);
        while ((k < 4 || nr < 4) && cyc < 60) begin
            if (nr < 4 && bif0.rsp_valid && !bif0.rsp_rw) begin rd[nr] = bif0.rsp_rdata; nr++; end
            if (k < 4 && bif0.cmd_ready) begin acc[k] = cyc; k++; end
            tick(); cyc++;
            if (k < 4) set_cmd(1'b0, 2'(k), 8'h00, 1'b1);
            else bif0.cmd_valid = 1'b0;
        end
        n_cmp++; if (nr != 4) begin n_bad++; $display("FAIL b2b_rd_count: got %0d want 4", nr); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (acc[i] - acc[i-1] != 3) begin n_bad++; $display("FAIL b2b_rd_gap%0d: got %0d want 3", i, acc[i] - acc[i-1]); end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rd[i] !== wv[i]) begin n_bad++; $display("FAIL b2b_rd_data%0d: got %h want %h", i, rd[i], wv[i]); end
        end
    endtask

    task automatic test_read_then_write();
        wait_ready();
        set_cmd(1'b0, 2'd1, 8'h00, 1'b1);
        tick();
        set_cmd(1'b1, 2'd1, 8'h5A, 1'b1);
        tick();
        n_cmp++; if (bif0.rsp_rdata !== 8'h22) begin n_bad++; $display("FAIL rw_rdata: got %h want 22", bif0.rsp_rdata); end
        n_cmp++; if (bif0.cmd_ready !== 1'b0 || !released(data0) && data0 !== 8'h22) begin n_bad++; $display("FAIL rw_turn: got ready %b data %h want 0/22", bif0.cmd_ready, data0); end
        tick();
        n_cmp++; if (bif0.cmd_ready !== 1'b1 || bif0.rsp_valid !== 1'b0 || bif0.ce !== 1'b0) begin n_bad++; $display("FAIL rw_idle: got ready %b rsp %b ce %b want 1/0/0", bif0.cmd_ready, bif0.rsp_valid, bif0.ce); end
        n_cmp++; if (!released(data0)) begin n_bad++; $display("FAIL rw_idle_bus: got %h want released", data0); end
        tick();
        bif0.cmd_valid = 1'b0;
        n_cmp++; if (bif0.ce !== 1'b1 || bif0.rw !== 1'b1 || data0 !== 8'h5A) begin n_bad++; $display("FAIL rw_write: got ce %b rw %b data %h want 1/1/5a", bif0.ce, bif0.rw, data0); end
        n_cmp++; if (r0_drive !== 1'b0) begin n_bad++; $display("FAIL rw_overlap: responder drive %b want 0", r0_drive); end
        tick();
        n_cmp++; if (bif0.rsp_valid !== 1'b1 || bif0.rsp_rw !== 1'b1 || bif0.rsp_rdata !== 8'h22) begin n_bad++; $display("FAIL rw_wr_rsp: got %b/%b/%h want 1/1/22", bif0.rsp_valid, bif0.rsp_rw, bif0.rsp_rdata); end
        n_cmp++; if (regs[1] !== 8'h5A) begin n_bad++; $display("FAIL rw_reg1: got %h want 5a", regs[1]); end
    endtask

    task automatic test_rdata_hold();
        wait_ready();
        set_cmd(1'b1, 2'd0, 8'h77, 1'b1);
        tick();
        set_cmd(1'b0, 2'd0, 8'h00, 1'b1);
        tick();
        n_cmp++; if (bif0.rsp_valid !== 1'b1 || bif0.rsp_rdata !== 8'h22) begin n_bad++; $display("FAIL hold_wr: got valid %b rdata %h want 1/22", bif0.rsp_valid, bif0.rsp_rdata); end
        tick();
        bif0.cmd_valid = 1'b0;
        n_cmp++; if (bif0.rsp_rdata !== 8'h22) begin n_bad++; $display("FAIL hold_access: got %h want 22", bif0.rsp_rdata); end
        tick();
        n_cmp++; if (bif0.rsp_valid !== 1'b1 || bif0.rsp_rdata !== 8'h77) begin n_bad++; $display("FAIL hold_rd: got valid %b rdata %h want 1/77", bif0.rsp_valid, bif0.rsp_rdata); end
    endtask

    task automatic test_timing_params();
        int ce_cnt, ce_first, rsp_cyc, rsp_cnt, rdy_cyc;
        ce_cnt = 0; ce_first = 0; rsp_cyc = 0; rsp_cnt = 0; rdy_cyc = 0;
        bif1.cmd_rw = 1'b0; bif1.cmd_addr = 2'd2; bif1.cmd_valid = 1'b1;
        tick();
        bif1.cmd_valid = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (bif1.ce) begin ce_cnt++; if (ce_first == 0) ce_first = c; end
            if (bif1.rsp_valid) begin rsp_cnt++; if (rsp_cyc == 0) rsp_cyc = c; end
            if (bif1.cmd_ready && rdy_cyc == 0) rdy_cyc = c;
            tick();
        end
        n_cmp++; if (ce_cnt != 3 || ce_first != 1) begin n_bad++; $display("FAIL slow_ce: got %0d cycles from %0d want 3 from 1", ce_cnt, ce_first); end
        n_cmp++; if (rsp_cyc != 4 || rsp_cnt != 1) begin n_bad++; $display("FAIL slow_rsp: got cycle %0d count %0d want 4/1", rsp_cyc, rsp_cnt); end
        n_cmp++; if (rdy_cyc != 6) begin n_bad++; $display("FAIL slow_ready: got cycle %0d want 6", rdy_cyc); end
        n_cmp++; if (bif1.rsp_rdata !== 8'h3C) begin n_bad++; $display("FAIL slow_rdata: got %h want 3c", bif1.rsp_rdata); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        wait_ready();
        set_cmd(1'b1, 2'd3, 8'hFF, 1'b1);
        tick();
        bif0.cmd_valid = 1'b0;
        n_cmp++; if (bif0.ce !== 1'b1 || data0 !== 8'hFF) begin n_bad++; $display("FAIL abort_pre: got ce %b data %h want 1/ff", bif0.ce, data0); end
        reset = 1'b1;
        tick();
        n_cmp++; if (bif0.ce !== 1'b0 || bif0.busy !== 1'b0 || bif0.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL abort_state: got ce %b busy %b rsp %b want 0/0/0", bif0.ce, bif0.busy, bif0.rsp_valid); end
        n_cmp++; if (!released(data0)) begin n_bad++; $display("FAIL abort_data: got %h want released", data0); end
        n_cmp++; if (bif0.cmd_ready !== 1'b0 || bif0.rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL abort_ready_rdata: got %b/%h want 0/00", bif0.cmd_ready, bif0.rsp_rdata); end
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (bif0.rsp_valid) pulses++;
            tick();
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL abort_rsp: got %0d pulses want 0", pulses); end
        n_cmp++; if (regs[3] !== 8'h44 && regs[3] !== 8'hFF) begin n_bad++; $display("FAIL abort_reg3: got %h want 44 or ff", regs[3]); end
        n_cmp++; if (bif0.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", bif0.cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_read_then_write();
        test_rdata_hold();
        test_timing_params();
        test_reset_abort();
        tick();
        n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL bus_ownership: got %0d violations want 0", viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
